apb_cmd_master: RTL and testbench

//  Parametrised APB4 master; second generation of the fixed-address 2-bit-command APB master.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_wait_timer.sv | 37 +++
 rtl/apb_cmd_master.sv | 148 ++++++++++++++
 tb/tb_apb_cmd_master.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB command master.
//   apb_state_e  : transfer FSM states (IDLE -> SETUP -> ACCESS)
//   APB_PROT_W   : width of pprot
//   timer_width  : counter width able to hold 0..limit, never narrower than 1 bit
package apb_pkg;

    localparam int unsigned APB_PROT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } apb_state_e;

    function automatic int unsigned timer_width(input int unsigned limit);
        int unsigned w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state timer for the APB ACCESS phase.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : clear the count (held during SETUP)
//   i_en           : count one wait state
//   o_expired      : count has reached LIMIT-1; never asserted when LIMIT == 0
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int unsigned LIMIT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned CNT_W = timer_width(LIMIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'((LIMIT == 0) ? 0 : LIMIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            // Saturate rather than wrap so a stuck slave cannot re-arm the limit.
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (LIMIT != 0) && (r_cnt == LAST);

endmodule

// File: rtl/apb_cmd_master.sv
// APB4 master: takes one transfer over a valid/ready request port, runs SETUP/ACCESS on
// the APB bus and returns read data / error over a single-slot valid/ready response port.
// Ports:
//   i_pclk, i_preset_n          : clock, asynchronous active-low reset
//   i_req_*  / o_req_ready      : request (write, addr, wdata, strb, prot)
//   o_rsp_*  / i_rsp_ready      : response (rdata, err, timeout), held until consumed
//   o_psel .. o_pprot           : APB master outputs
//   i_prdata, i_pready, i_pslverr : APB slave returns
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  i_pclk,
    input  logic                  i_preset_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_write,
    input  logic [ADDR_W-1:0]     i_req_addr,
    input  logic [DATA_W-1:0]     i_req_wdata,
    input  logic [DATA_W/8-1:0]   i_req_strb,
    input  logic [APB_PROT_W-1:0] i_req_prot,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_W-1:0]     o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_rsp_timeout,
    output logic                  o_psel,
    output logic                  o_penable,
    output logic                  o_pwrite,
    output logic [ADDR_W-1:0]     o_paddr,
    output logic [DATA_W-1:0]     o_pwdata,
    output logic [DATA_W/8-1:0]   o_pstrb,
    output logic [APB_PROT_W-1:0] o_pprot,
    input  logic [DATA_W-1:0]     i_prdata,
    input  logic                  i_pready,
    input  logic                  i_pslverr
);

    apb_state_e            r_state;
    apb_state_e            w_state_nxt;
    logic                  r_write;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_strb;
    logic [APB_PROT_W-1:0] r_prot;
    logic                  r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;

    logic w_accept;
    logic w_done;
    logic w_abort;
    logic w_expired;

    // Requests are held off while the response slot is occupied.
    assign o_req_ready = (r_state == ST_IDLE) && !r_rsp_valid;
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_done      = (r_state == ST_ACCESS) && i_pready;
    // pready on the limit cycle wins over the timeout.
    assign w_abort     = (r_state == ST_ACCESS) && !i_pready && w_expired;

    apb_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .i_clk     (i_pclk),
        .i_rst_n   (i_preset_n),
        .i_clr     (r_state == ST_SETUP),
        .i_en      ((r_state == ST_ACCESS) && !i_pready),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (w_done || w_abort) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_pclk or negedge i_preset_n) begin
        if (!i_preset_n) begin
            r_state       <= ST_IDLE;
            r_write       <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_strb        <= '0;
            r_prot        <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_write <= i_req_write;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
                r_strb  <= i_req_strb;
                r_prot  <= i_req_prot;
            end
            if (w_done) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_err     <= i_pslverr;
                r_rsp_timeout <= 1'b0;
                r_rsp_rdata   <= r_write ? '0 : i_prdata;
            end else if (w_abort) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_err     <= 1'b1;
                r_rsp_timeout <= 1'b1;
                r_rsp_rdata   <= '0;
            end else if (r_rsp_valid && i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        o_psel    = 1'b0;
        o_penable = 1'b0;
        o_pwrite  = 1'b0;
        o_paddr   = '0;
        o_pwdata  = '0;
        o_pstrb   = '0;
        o_pprot   = '0;
        if (r_state != ST_IDLE) begin
            o_psel    = 1'b1;
            o_penable = (r_state == ST_ACCESS);
            o_pwrite  = r_write;
            o_paddr   = r_addr;
            o_pwdata  = r_wdata;
            // Reads carry no strobes on the bus.
            o_pstrb   = r_write ? r_strb : '0;
            o_pprot   = r_prot;
        end
    end

    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_err     = r_rsp_err;
    assign o_rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: directed transfers followed by random ones against
// a small APB slave model; expected responses come from a transaction-level model.
module tb_apb_cmd_master;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [SW-1:0] req_strb = '0;
    logic [2:0]    req_prot = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [2:0]    pprot;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;

    always #5 clk = ~clk;

    apb_cmd_master #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_pclk        (clk),
        .i_preset_n    (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_write   (req_write),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .i_req_strb    (req_strb),
        .i_req_prot    (req_prot),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_rdata   (rsp_rdata),
        .o_rsp_err     (rsp_err),
        .o_rsp_timeout (rsp_timeout),
        .o_psel        (psel),
        .o_penable     (penable),
        .o_pwrite      (pwrite),
        .o_paddr       (paddr),
        .o_pwdata      (pwdata),
        .o_pstrb       (pstrb),
        .o_pprot       (pprot),
        .i_prdata      (prdata),
        .i_pready      (pready),
        .i_pslverr     (pslverr)
    );

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
        int unsigned   waits;   // slave wait states before pready
        logic          err;     // pslverr on the ready cycle
        logic [DW-1:0] rdata;   // slave read data
    } xfer_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          timeout;
        int unsigned   lat;
        int unsigned   acc_cyc;
        bit            seen;
    } exp_t;

    exp_t        sb[$];
    xfer_t       slv_q[$];
    xfer_t       cur;
    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level expectation: slow slaves time out, otherwise the slave answer stands.
    function automatic exp_t model(input xfer_t x);
        exp_t e;
        bit   to;
        to        = (TO != 0) && (x.waits >= TO);
        e.timeout = to;
        e.err     = to ? 1'b1 : x.err;
        e.rdata   = (to || x.write) ? '0 : x.rdata;
        e.lat     = to ? 2 + TO : 3 + x.waits;
        e.acc_cyc = 0;
        e.seen    = 0;
        return e;
    endfunction

    function automatic xfer_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input logic [SW-1:0] s, input logic [2:0] p,
                                 input int unsigned wt, input logic er, input logic [DW-1:0] rd);
        xfer_t x;
        x.write = w; x.addr = a; x.wdata = d; x.strb = s; x.prot = p;
        x.waits = wt; x.err = er; x.rdata = rd;
        return x;
    endfunction

    function automatic xfer_t rand_xfer();
        return mk(1'($urandom), AW'($urandom), DW'($urandom), SW'($urandom), 3'($urandom),
                  $urandom_range(0, 6), ($urandom_range(0, 3) == 0), DW'($urandom));
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Response back-pressure, with occasional 5-cycle stalls.
    initial begin
        int stall;
        stall = 0;
        forever begin
            @(posedge clk);
            #1;
            if (stall > 0) begin
                rsp_ready = 1'b0;
                stall--;
            end else if ($urandom_range(0, 7) == 0) begin
                rsp_ready = 1'b0;
                stall = 4;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor / scoreboard.
    initial forever begin
        exp_t h;
        @(negedge clk);
        if (rst_n) begin
            check("req_ready", req_ready, sb.size() == 0);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp_valid", rsp_valid, 0);
                end else begin
                    h = sb[0];
                    if (!h.seen) begin
                        check("rsp_latency", cyc - h.acc_cyc, h.lat);
                        check("psel_after_end", psel, 0);
                        h.seen = 1;
                        sb[0] = h;
                    end
                    check("rsp_rdata", rsp_rdata, h.rdata);
                    check("rsp_err", rsp_err, h.err);
                    check("rsp_timeout", rsp_timeout, h.timeout);
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
            if (req_valid && req_ready) begin
                h = model(cur);
                h.acc_cyc = cyc;
                sb.push_back(h);
                slv_q.push_back(cur);
            end
        end
    end

    task automatic check_pins(input xfer_t s);
        check("paddr", paddr, s.addr);
        check("pwrite", pwrite, s.write);
        check("pwdata", pwdata, s.wdata);
        check("pstrb", pstrb, s.write ? s.strb : '0);
        check("pprot", pprot, s.prot);
    endtask

    // APB slave model: answers after the planned number of wait states.
    initial begin
        xfer_t       s;
        bit          have;
        int unsigned cnt;
        have = 0;
        cnt  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have   = 0;
                pready = 1'b0;
            end else if (psel && !penable) begin
                if (slv_q.size() == 0) begin
                    check("setup_without_request", psel, 0);
                    have = 0;
                end else begin
                    s    = slv_q.pop_front();
                    have = 1;
                    check_pins(s);
                end
                cnt     = 0;
                pready  = 1'b0;
                pslverr = 1'($urandom);
            end else if (psel && penable) begin
                if (!have) begin
                    check("access_without_setup", penable, 0);
                end else begin
                    check_pins(s);
                end
                if (have && cnt == s.waits) begin
                    pready  = 1'b1;
                    pslverr = s.err;
                    prdata  = s.write ? DW'($urandom) : s.rdata;
                end else begin
                    pready  = 1'b0;
                    pslverr = 1'($urandom);
                    prdata  = DW'($urandom);
                    cnt++;
                end
            end else begin
                check("penable_idle", penable, 0);
                pready = 1'b0;
            end
        end
    end

    task automatic issue(input xfer_t x);
        int n;
        cur       = x;
        req_write = x.write;
        req_addr  = x.addr;
        req_wdata = x.wdata;
        req_strb  = x.strb;
        req_prot  = x.prot;
        req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 60);
        if (!req_ready) check("req_ready_wait_bound", 0, 1);
        @(posedge clk);
        #1;
        // Garbage on the request port must not disturb the transfer in flight.
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
        req_strb  = SW'($urandom);
        req_prot  = 3'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_bound", sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_psel"}, psel, 0);
        check({tag, "_penable"}, penable, 0);
        check({tag, "_paddr"}, paddr, 0);
        check({tag, "_pstrb"}, pstrb, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_rsp_timeout"}, rsp_timeout, 0);
        check({tag, "_req_ready"}, req_ready, 1);
    endtask

    initial begin
        xfer_t dir[$];
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        dir.push_back(mk(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 3'd0, 0, 1'b0, 32'h0));
        dir.push_back(mk(1'b0, 32'h2004, 32'h0, 4'hF, 3'd1, 2, 1'b0, 32'hCAFEF00D));
        dir.push_back(mk(1'b1, 32'h3008, 32'h12345678, 4'h5, 3'd2, 1, 1'b1, 32'h0));
        dir.push_back(mk(1'b0, 32'h4000, 32'h0, 4'h0, 3'd3, 9, 1'b0, 32'h11111111));
        dir.push_back(mk(1'b0, 32'h4004, 32'h0, 4'h0, 3'd4, TO - 1, 1'b0, 32'hA5A5A5A5));
        dir.push_back(mk(1'b1, 32'h4008, 32'hFFFF0000, 4'h3, 3'd5, TO, 1'b0, 32'h0));
        foreach (dir[i]) issue(dir[i]);

        for (int i = 0; i < 80; i++) begin
            issue(rand_xfer());
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();

        // Reset in the middle of an ACCESS phase.
        issue(mk(1'b0, 32'h5000, 32'h0, 4'h0, 3'd0, 9, 1'b0, 32'h77777777));
        @(posedge clk);
        #2;
        check("mid_penable_before_reset", penable, 1);
        rst_n = 1'b0;
        sb.delete();
        slv_q.delete();
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_rsp_valid", rsp_valid, 0);
        check("post_reset_req_ready", req_ready, 1);
        @(posedge clk);
        #1;
        issue(mk(1'b0, 32'h6000, 32'h0, 4'h0, 3'd6, 1, 1'b0, 32'h0BADCAFE));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
